prog_counter_ctrl: RTL and testbench

- Program counter and program-sequencing controller. Sits directly upstream and downstream of the branch-target lookup table.
- Drives the 2-bit ProgState that selects the lookup table's program bank.
- Consumes the 10-bit Target the lookup table returns, and produces the instruction-memory fetch address PC.
- Handles the Start/Done handshake with the testbench/top level, and steps through programs 0→1→2.

---
 rtl/prog_pkg.sv | 20 ++
 rtl/pc_reg.sv | 25 ++
 rtl/prog_counter_ctrl.sv | 112 +++++++++++
 tb/tb_prog_counter_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// rtl/prog_pkg.sv - shared types and constants for the program sequencer
package prog_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ctrl_state_t;

   localparam int PC_W      = 10;
   localparam int NUM_PROGS = 3;

   typedef logic [PC_W-1:0] pc_t;

   // Program index steps 0->1->2->0; any out-of-range index restarts at 0.
   function automatic logic [1:0] next_prog(input logic [1:0] p);
      return (p >= 2'(NUM_PROGS - 1)) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with load, increment and hold
module pc_reg #(
   parameter int           W         = 10,
   parameter logic [W-1:0] RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         inc,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] pc
);

   // Load beats increment; increment wraps modulo 2^W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_VAL;
      end else if (load) begin
         pc <= load_value;
      end else if (inc) begin
         pc <= pc + W'(1);
      end
   end

endmodule

// File: rtl/prog_counter_ctrl.sv
// rtl/prog_counter_ctrl.sv - PC and program sequencing FSM (IDLE/RUN/DONE)
module prog_counter_ctrl
   import prog_pkg::*;
#(
   parameter int              PC_W  = prog_pkg::PC_W,
   parameter logic [PC_W-1:0] BASE0 = 10'd0,
   parameter logic [PC_W-1:0] BASE1 = 10'd256,
   parameter logic [PC_W-1:0] BASE2 = 10'd512,
   parameter int              CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Stall,
   input  logic             Halt,
   input  logic             BranchTaken,
   input  logic [PC_W-1:0]  Target,
   output logic [PC_W-1:0]  PC,
   output logic [1:0]       ProgState,
   output logic             Running,
   output logic             Done,
   output logic [CNT_W-1:0] CycleCount
);

   ctrl_state_t      state, state_nxt;
   logic [1:0]       prog_nxt;
   logic             pc_load, pc_inc;
   logic [PC_W-1:0]  pc_value;
   logic             cnt_clr, cnt_inc;

   function automatic logic [PC_W-1:0] base_of(input logic [1:0] p);
      case (p)
         2'd1:    return BASE1;
         2'd2:    return BASE2;
         default: return BASE0;
      endcase
   endfunction

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         ProgState  <= 2'd0;
         CycleCount <= '0;
      end else begin
         state     <= state_nxt;
         ProgState <= prog_nxt;
         if (cnt_clr) begin
            CycleCount <= '0;
         end else if (cnt_inc && (CycleCount != {CNT_W{1'b1}})) begin
            CycleCount <= CycleCount + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      prog_nxt  = ProgState;
      pc_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_value  = PC;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         RUN: begin
            // Stall freezes everything; Halt outranks a taken branch.
            if (!Stall) begin
               cnt_inc = 1'b1;
               if (Halt) begin
                  state_nxt = DONE;
               end else if (BranchTaken) begin
                  pc_load  = 1'b1;
                  pc_value = Target;
               end else begin
                  pc_inc = 1'b1;
               end
            end
         end
         DONE: begin
            if (!Start) begin
               state_nxt = IDLE;
               prog_nxt  = next_prog(ProgState);
               pc_load   = 1'b1;
               pc_value  = base_of(next_prog(ProgState));
            end
         end
         default: begin
            pc_load  = 1'b1;
            pc_value = base_of(ProgState);
            if (Start) begin
               state_nxt = RUN;
               cnt_clr   = 1'b1;
            end
         end
      endcase
   end

   pc_reg #(
      .W         (PC_W),
      .RESET_VAL (BASE0)
   ) u_pc_reg (
      .clk        (Clk),
      .rst_n      (Reset_n),
      .load       (pc_load),
      .inc        (pc_inc),
      .load_value (pc_value),
      .pc         (PC)
   );

   assign Running = (state == RUN);
   assign Done    = (state == DONE);

endmodule

// File: tb/tb_prog_counter_ctrl.sv
// tb/tb_prog_counter_ctrl.sv - directed self-checking bench for prog_counter_ctrl
module tb_prog_counter_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stall, halt, branch_taken;
   logic [9:0]  target;
   logic [9:0]  pc;
   logic [1:0]  prog_state;
   logic        running, done;
   logic [15:0] cycle_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   prog_counter_ctrl dut (
      .Clk         (clk),
      .Reset_n     (rst_n),
      .Start       (start),
      .Stall       (stall),
      .Halt        (halt),
      .BranchTaken (branch_taken),
      .Target      (target),
      .PC          (pc),
      .ProgState   (prog_state),
      .Running     (running),
      .Done        (done),
      .CycleCount  (cycle_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; start = 0; stall = 0; halt = 0; branch_taken = 0; target = '0;
      tick(); tick();
      check("rst_pc", pc, 0);
      check("rst_prog", prog_state, 0);
      check("rst_running", running, 0);
      check("rst_done", done, 0);
      check("rst_count", cycle_count, 0);
      rst_n = 1'b1;
      tick();
      check("idle_pc", pc, 0);

      // Program 0: sequential run, halt on fifth RUN cycle
      start = 1; tick(); start = 0;
      check("p0_running", running, 1);
      check("p0_first_pc", pc, 0);
      check("p0_count0", cycle_count, 0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("p0_seq_pc", pc, i);
      end
      halt = 1; tick(); halt = 0;
      check("p0_done", done, 1);
      check("p0_halt_pc", pc, 4);
      check("p0_count", cycle_count, 5);
      check("p0_prog", prog_state, 0);
      tick();
      check("p1_idle_prog", prog_state, 1);
      check("p1_idle_pc", pc, 256);
      check("p1_idle_done", done, 0);

      // Program 1: branch then halt+branch together
      start = 1; tick(); start = 0;
      check("p1_first_pc", pc, 256);
      tick(); tick(); tick();
      check("p1_pre_branch", pc, 259);
      branch_taken = 1; target = 10'd40; tick(); branch_taken = 0;
      check("p1_branch_pc", pc, 40);
      tick();
      check("p1_after_branch", pc, 41);
      halt = 1; branch_taken = 1; target = 10'd100; tick();
      halt = 0; branch_taken = 0;
      check("p1_halt_wins_done", done, 1);
      check("p1_halt_wins_pc", pc, 41);
      check("p1_count", cycle_count, 6);
      tick();
      check("p2_idle_prog", prog_state, 2);
      check("p2_idle_pc", pc, 512);

      // Program 2: stall with halt ignored mid-stall
      start = 1; tick(); start = 0;
      for (int i = 0; i < 7; i++) tick();
      check("p2_pre_stall_pc", pc, 519);
      check("p2_pre_stall_cnt", cycle_count, 7);
      stall = 1; tick();
      check("stall1_pc", pc, 519);
      halt = 1; tick(); halt = 0;
      check("stall2_pc", pc, 519);
      check("stall2_running", running, 1);
      check("stall2_cnt", cycle_count, 7);
      tick();
      check("stall3_pc", pc, 519);
      stall = 0; halt = 1; tick(); halt = 0;
      check("stall_release_done", done, 1);
      check("stall_release_pc", pc, 519);
      check("stall_release_cnt", cycle_count, 8);
      start = 1; tick();
      check("done_hold_start", done, 1);
      check("done_hold_cnt", cycle_count, 8);
      start = 0; tick();
      check("p0b_idle_prog", prog_state, 0);
      check("p0b_idle_pc", pc, 0);

      // Wrap at top of address space
      start = 1; tick(); start = 0;
      branch_taken = 1; target = 10'h3FF; tick(); branch_taken = 0;
      check("wrap_top", pc, 10'h3FF);
      tick();
      check("wrap_zero", pc, 0);
      halt = 1; tick(); halt = 0;
      check("wrap_done", done, 1);
      tick();
      check("p1b_idle_pc", pc, 256);

      // Async reset between clock edges mid-RUN
      start = 1; tick(); start = 0;
      branch_taken = 1; target = 10'd300; tick(); branch_taken = 0;
      check("ar_pre_pc", pc, 300);
      check("ar_pre_prog", prog_state, 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_pc", pc, 0);
      check("ar_prog", prog_state, 0);
      check("ar_running", running, 0);
      check("ar_done", done, 0);
      check("ar_count", cycle_count, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("ar_idle_pc", pc, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
